mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory stage of the 5-stage MIPS pipeline, directly downstream of the execute stage.
- Contains the E/M pipeline register, which captures the execute results, store data and exception state.
- Drives the data-memory/device bus: address, write data and byte enables.
- Detects address exceptions (AdEL/AdES), extends load data, and feeds M_EResult back to the execute-stage forwarding muxes.

Parameters:
DM_TOP, 32'h0000_2FFF, last valid DM byte address (DM base is 0)
TC0_BASE, 32'h0000_7F00, timer0 register window base (12 bytes)
TC1_BASE, 32'h0000_7F10, timer1 register window base (12 bytes)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
IntExcReq  in  1  interrupt/exception taken this cycle; flushes and suppresses store
E_Instr  in  32  instruction leaving E
E_PC  in  32  PC of E instruction
E_BD  in  1  E instruction is in a delay slot
E_EResult  in  32  ALU/MDU result (load/store address for mem ops)
E_RData2  in  32  forwarded rt value (store data)
E_WriteA  in  5  destination GPR
E_ExcCode  in  5  exception code from E (0 = none)
W_GRFWData  in  32  W-stage writeback value for store-data forwarding
Trans_DMWData_Sel  in  1  1: store data = W_GRFWData
M_Instr  out  32  registered instruction
M_PC  out  32  registered PC
M_BD  out  1  registered delay-slot flag
M_EResult  out  32  registered result; forwarding source for E
M_WriteA  out  5  registered destination
ExcCode  out  5  final M exception code
DMAddr  out  32  bus address (= M_EResult)
DMWData  out  32  byte-lane-replicated store data
DMByteEn  out  4  byte write enables
DMRData  in  32  combinational bus read data
LoadData  out  32  aligned, extended load result for the W register

Behaviour:
- E/M register, updates every rising edge.
  - If reset or IntExcReq: all fields are 0 (bubble: Instr=0, PC=0, BD=0, ExcCode=0, WriteA=0).
  - Otherwise: all fields take their E_* values.
  - No stall input. M never holds; the hazard unit inserts bubbles at E.
- Reset value of every registered output is 0. DMByteEn and ExcCode are 0 after reset.
- Store data:
  - Before replication, store data is the registered rt value, or W_GRFWData when Trans_DMWData_Sel=1.
  - sw: passed as-is. sh: {2{d[15:0]}}. sb: {4{d[7:0]}}.
- Byte enables:
  - sw: 4'b1111.
  - sh: addr[1] ? 4'b1100 : 4'b0011.
  - sb: 4'b0001 << addr[1:0].
  - Forced to 4'b0000 when: not a store, ExcCode!=0, or IntExcReq=1 (same-cycle interrupt must not commit the store).
- Exception code, combinational from registered fields:
  - Registered ExcCode!=0 and not 12: pass through unchanged (E has priority).
  - Registered ExcCode==12 (address-add overflow, reported by E as Ov): load → 4 (AdEL), store → 5 (AdES). Non-memory instructions keep 12.
  - Otherwise, loads (lw/lh/lhu/lb/lbu) → 4 when any of:
    - lw with addr[1:0]!=0;
    - lh/lhu with addr[0]!=0;
    - lh/lhu/lb/lbu with an address in a timer window;
    - address outside [0, DM_TOP] and outside both timer windows.
  - Otherwise, stores (sw/sh/sb) → 5 under the same rules, plus a store to timer offset 8 (the COUNT register).
  - Window membership is on the full 32-bit address, e.g. TC0 = [0x7F00, 0x7F0B].
- Load extension:
  - lw: full word.
  - lh / lhu: half selected by addr[1], sign- / zero-extended.
  - lb / lbu: byte selected by addr[1:0], sign- / zero-extended.
  - Non-load instructions: LoadData = 0.
- Latency: one cycle from E inputs to M outputs. Everything downstream of the register is combinational.
- Instr=0 (nop/bubble) produces no bus write and ExcCode=0.

Decomposition:
- Shared package (mips_defs):
  - opcode constants for the eight load/store ops;
  - ExcCode constants Int=0, AdEL=4, AdES=5, RI=10, Ov=12;
  - address-map constants DM_TOP, TC0_BASE, TC1_BASE, TC_COUNT_OFS=8.
- One sub-module, data_ext: combinational load aligner/extender.
  - Inputs: address low bits, load type, DMRData.
  - Output: LoadData.

Test Plan:
- sw $t (=0x12345678) to 0x0000_0004, Trans_DMWData_Sel=0 → next cycle DMAddr=0x4, DMWData=0x12345678, DMByteEn=1111, ExcCode=0.
- sb, rt=0x000000AB, addr 0x0000_0102 → DMWData=0xABABABAB, DMByteEn=0100. lb, DMRData=0x00AB0000, addr 0x102 → LoadData=0xFFFFFFAB. lbu, same → 0x000000AB.
- lh at 0x0000_0003 → ExcCode=4, DMByteEn=0. sw to 0x0000_7F08 → ExcCode=5, DMByteEn=0. sw to 0x0000_7F04 → ExcCode=0, DMByteEn=1111.
- E_ExcCode=12 with lw → ExcCode=4. E_ExcCode=12 with add → ExcCode=12. E_ExcCode=10 with sw → ExcCode=10, DMByteEn=0.
- Store in M while IntExcReq=1 → DMByteEn=0 that cycle. Next cycle M_Instr=0, M_PC=0, ExcCode=0.
- Store-data forwarding: Trans_DMWData_Sel=1, W_GRFWData=0xCAFEBABE, sh at 0x2 → DMWData=0xBABEBABE, DMByteEn=1100.
- reset asserted mid-stream → all outputs 0 on the next edge.

Source files
------------

// File: rtl/mips_defs.sv
// Shared definitions for the MIPS pipeline memory stage: load/store opcodes,
// exception codes, the data-memory/timer address map and small decode helpers.
package mips_defs;

    // Load/store primary opcodes (instr[31:26])
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    // Exception codes
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Address map: DM starts at 0, two 12-byte timer register windows
    localparam logic [31:0] DM_TOP       = 32'h0000_2FFF;
    localparam logic [31:0] TC0_BASE     = 32'h0000_7F00;
    localparam logic [31:0] TC1_BASE     = 32'h0000_7F10;
    localparam logic [31:0] TC_COUNT_OFS = 32'h0000_0008;
    localparam logic [31:0] TC_WIN_SIZE  = 32'h0000_000C;

    typedef enum logic [2:0] {
        LT_NONE = 3'd0,
        LT_W    = 3'd1,
        LT_H    = 3'd2,
        LT_HU   = 3'd3,
        LT_B    = 3'd4,
        LT_BU   = 3'd5
    } load_type_e;

    typedef enum logic [1:0] {
        ST_NONE = 2'd0,
        ST_W    = 2'd1,
        ST_H    = 2'd2,
        ST_B    = 2'd3
    } store_type_e;

    function automatic load_type_e decode_load(input logic [5:0] op);
        load_type_e lt;
        case (op)
            OP_LW:   lt = LT_W;
            OP_LH:   lt = LT_H;
            OP_LHU:  lt = LT_HU;
            OP_LB:   lt = LT_B;
            OP_LBU:  lt = LT_BU;
            default: lt = LT_NONE;
        endcase
        return lt;
    endfunction

    function automatic store_type_e decode_store(input logic [5:0] op);
        store_type_e st;
        case (op)
            OP_SW:   st = ST_W;
            OP_SH:   st = ST_H;
            OP_SB:   st = ST_B;
            default: st = ST_NONE;
        endcase
        return st;
    endfunction

    // True when addr falls inside the 12-byte register window starting at base
    function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base);
        return (addr >= base) && ((addr - base) < TC_WIN_SIZE);
    endfunction

endpackage

// File: rtl/data_ext.sv
// Load aligner/extender: picks the addressed byte/half out of the bus word
// and sign- or zero-extends it according to the load type.
module data_ext
    import mips_defs::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  load_type,
    input  logic [31:0] rdata,
    output logic [31:0] load_data
);

    logic [15:0] half_s;
    logic [7:0]  byte_s;

    // Select the addressed halfword and byte lane
    always_comb begin
        half_s = rdata[15:0];
        byte_s = rdata[7:0];
        if (addr_lo[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
        case (addr_lo)
            2'b00:   byte_s = rdata[7:0];
            2'b01:   byte_s = rdata[15:8];
            2'b10:   byte_s = rdata[23:16];
            2'b11:   byte_s = rdata[31:24];
            default: byte_s = rdata[7:0];
        endcase
    end

    // Extend the selected data to 32 bits; non-loads return zero
    always_comb begin
        load_data = 32'h0000_0000;
        case (load_type_e'(load_type))
            LT_W:    load_data = rdata;
            LT_H:    load_data = {{16{half_s[15]}}, half_s};
            LT_HU:   load_data = {16'h0000, half_s};
            LT_B:    load_data = {{24{byte_s[7]}}, byte_s};
            LT_BU:   load_data = {24'h00_0000, byte_s};
            default: load_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: E/M pipeline register, data bus drive (address, lane-
// replicated store data, byte enables), AdEL/AdES detection and load extension.
module mem_stage
    import mips_defs::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        IntExcReq,
    input  logic [31:0] E_Instr,
    input  logic [31:0] E_PC,
    input  logic        E_BD,
    input  logic [31:0] E_EResult,
    input  logic [31:0] E_RData2,
    input  logic [4:0]  E_WriteA,
    input  logic [4:0]  E_ExcCode,
    input  logic [31:0] W_GRFWData,
    input  logic        Trans_DMWData_Sel,
    output logic [31:0] M_Instr,
    output logic [31:0] M_PC,
    output logic        M_BD,
    output logic [31:0] M_EResult,
    output logic [4:0]  M_WriteA,
    output logic [4:0]  ExcCode,
    output logic [31:0] DMAddr,
    output logic [31:0] DMWData,
    output logic [3:0]  DMByteEn,
    input  logic [31:0] DMRData,
    output logic [31:0] LoadData
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic        bd_q, bd_d;
    logic [31:0] eresult_q, eresult_d;
    logic [31:0] rdata2_q, rdata2_d;
    logic [4:0]  writea_q, writea_d;
    logic [4:0]  exccode_q, exccode_d;

    load_type_e  lt_s;
    store_type_e st_s;
    logic        is_load_s;
    logic        is_store_s;
    logic        in_dm_s;
    logic        in_tc0_s;
    logic        in_tc1_s;
    logic        in_tc_s;
    logic [31:0] tc_ofs_s;
    logic        count_s;
    logic        misalign_s;
    logic        sub_word_s;
    logic        addr_err_s;
    logic [4:0]  exc_s;
    logic [31:0] st_data_s;
    logic [31:0] wdata_s;
    logic [3:0]  be_s;

    // Next E/M contents: a taken interrupt/exception turns the slot into a bubble
    always_comb begin
        instr_d   = E_Instr;
        pc_d      = E_PC;
        bd_d      = E_BD;
        eresult_d = E_EResult;
        rdata2_d  = E_RData2;
        writea_d  = E_WriteA;
        exccode_d = E_ExcCode;
        if (IntExcReq) begin
            instr_d   = 32'h0000_0000;
            pc_d      = 32'h0000_0000;
            bd_d      = 1'b0;
            eresult_d = 32'h0000_0000;
            rdata2_d  = 32'h0000_0000;
            writea_d  = 5'd0;
            exccode_d = 5'd0;
        end else begin
            instr_d   = E_Instr;
        end
    end

    // E/M pipeline register; M never stalls, it only takes bubbles
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q   <= 32'h0000_0000;
            pc_q      <= 32'h0000_0000;
            bd_q      <= 1'b0;
            eresult_q <= 32'h0000_0000;
            rdata2_q  <= 32'h0000_0000;
            writea_q  <= 5'd0;
            exccode_q <= 5'd0;
        end else begin
            instr_q   <= instr_d;
            pc_q      <= pc_d;
            bd_q      <= bd_d;
            eresult_q <= eresult_d;
            rdata2_q  <= rdata2_d;
            writea_q  <= writea_d;
            exccode_q <= exccode_d;
        end
    end

    // Classify the access and check alignment / address-map legality
    always_comb begin
        lt_s       = decode_load(instr_q[31:26]);
        st_s       = decode_store(instr_q[31:26]);
        is_load_s  = (lt_s != LT_NONE);
        is_store_s = (st_s != ST_NONE);
        in_dm_s    = (eresult_q <= DM_TOP);
        in_tc0_s   = in_window(eresult_q, TC0_BASE);
        in_tc1_s   = in_window(eresult_q, TC1_BASE);
        in_tc_s    = in_tc0_s | in_tc1_s;
        if (in_tc0_s) begin
            tc_ofs_s = eresult_q - TC0_BASE;
        end else begin
            tc_ofs_s = eresult_q - TC1_BASE;
        end
        // COUNT is read-only from the CPU side
        count_s    = in_tc_s && (tc_ofs_s[31:2] == TC_COUNT_OFS[31:2]);
        misalign_s = 1'b0;
        sub_word_s = 1'b0;
        case (lt_s)
            LT_W:        misalign_s = (eresult_q[1:0] != 2'b00);
            LT_H, LT_HU: begin
                misalign_s = eresult_q[0];
                sub_word_s = 1'b1;
            end
            LT_B, LT_BU: sub_word_s = 1'b1;
            default:     misalign_s = 1'b0;
        endcase
        case (st_s)
            ST_W:    misalign_s = (eresult_q[1:0] != 2'b00);
            ST_H:    begin
                misalign_s = eresult_q[0];
                sub_word_s = 1'b1;
            end
            ST_B:    sub_word_s = 1'b1;
            default: sub_word_s = sub_word_s;
        endcase
        // Timer registers are word-only; anything outside DM and timers is unmapped
        addr_err_s = misalign_s | (sub_word_s & in_tc_s) | (~in_dm_s & ~in_tc_s);
    end

    // Final exception code: upstream codes win, except address-add overflow on mem ops
    always_comb begin
        exc_s = exccode_q;
        if (exccode_q == EXC_OV) begin
            if (is_load_s) begin
                exc_s = EXC_ADEL;
            end else if (is_store_s) begin
                exc_s = EXC_ADES;
            end else begin
                exc_s = EXC_OV;
            end
        end else if (exccode_q != EXC_INT) begin
            exc_s = exccode_q;
        end else if (is_load_s && addr_err_s) begin
            exc_s = EXC_ADEL;
        end else if (is_store_s && (addr_err_s || count_s)) begin
            exc_s = EXC_ADES;
        end else begin
            exc_s = EXC_INT;
        end
    end

    // Store data source, lane replication and byte enables
    always_comb begin
        if (Trans_DMWData_Sel) begin
            st_data_s = W_GRFWData;
        end else begin
            st_data_s = rdata2_q;
        end
        wdata_s = st_data_s;
        be_s    = 4'b0000;
        case (st_s)
            ST_W: begin
                wdata_s = st_data_s;
                be_s    = 4'b1111;
            end
            ST_H: begin
                wdata_s = {2{st_data_s[15:0]}};
                be_s    = eresult_q[1] ? 4'b1100 : 4'b0011;
            end
            ST_B: begin
                wdata_s = {4{st_data_s[7:0]}};
                be_s    = 4'b0001 << eresult_q[1:0];
            end
            default: be_s = 4'b0000;
        endcase
        // A faulting store, or one caught by a same-cycle interrupt, must not commit
        if (!is_store_s || (exc_s != EXC_INT) || IntExcReq) begin
            be_s = 4'b0000;
        end else begin
            be_s = be_s;
        end
    end

    data_ext u_data_ext (
        .addr_lo   (eresult_q[1:0]),
        .load_type (lt_s),
        .rdata     (DMRData),
        .load_data (LoadData)
    );

    assign M_Instr   = instr_q;
    assign M_PC      = pc_q;
    assign M_BD      = bd_q;
    assign M_EResult = eresult_q;
    assign M_WriteA  = writea_q;
    assign ExcCode   = exc_s;
    assign DMAddr    = eresult_q;
    assign DMWData   = wdata_s;
    assign DMByteEn  = be_s;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: the stimulus pushes each captured M-stage
// record into a queue, the monitor pops it on the falling edge and compares
// the DUT against a behavioural model of the memory-stage rules.
module tb_mem_stage;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] eres;
        logic [31:0] rt;
        logic        bd;
        logic [4:0]  wa;
        logic [4:0]  exc;
    } ein_t;

    typedef struct packed {
        logic        sel;
        logic [31:0] w;
        logic [31:0] rd;
        logic        intr;
    } mside_t;

    // mask bits: [3] byte enables, [2] exception code, [1] write data, [0] load data
    typedef struct packed {
        logic [3:0]  mask;
        logic [3:0]  be;
        logic [4:0]  exc;
        logic [31:0] wd;
        logic [31:0] ld;
    } spot_t;

    typedef struct packed {
        logic   bubble;
        ein_t   e;
        mside_t m;
        spot_t  s;
    } rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    ein_t   e_drv   = '0;
    mside_t m_drv   = '0;
    logic   rst_drv = 1'b1;

    logic [31:0] M_Instr, M_PC, M_EResult, DMAddr, DMWData, LoadData;
    logic        M_BD;
    logic [4:0]  M_WriteA, ExcCode;
    logic [3:0]  DMByteEn;

    mem_stage dut (
        .clk               (clk),
        .reset             (rst_drv),
        .IntExcReq         (m_drv.intr),
        .E_Instr           (e_drv.instr),
        .E_PC              (e_drv.pc),
        .E_BD              (e_drv.bd),
        .E_EResult         (e_drv.eres),
        .E_RData2          (e_drv.rt),
        .E_WriteA          (e_drv.wa),
        .E_ExcCode         (e_drv.exc),
        .W_GRFWData        (m_drv.w),
        .Trans_DMWData_Sel (m_drv.sel),
        .M_Instr           (M_Instr),
        .M_PC              (M_PC),
        .M_BD              (M_BD),
        .M_EResult         (M_EResult),
        .M_WriteA          (M_WriteA),
        .ExcCode           (ExcCode),
        .DMAddr            (DMAddr),
        .DMWData           (DMWData),
        .DMByteEn          (DMByteEn),
        .DMRData           (m_drv.rd),
        .LoadData          (LoadData)
    );

    rec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   pushed = 0;
    int   popped = 0;

    localparam logic [31:0] ADD_I = 32'h0109_5020;
    logic [5:0] ops [8] = '{6'h23, 6'h21, 6'h25, 6'h20, 6'h24, 6'h2B, 6'h29, 6'h28};

    function automatic logic [31:0] mop(input logic [5:0] op);
        return {op, 5'd4, 5'd9, 16'h0000};
    endfunction

    function automatic ein_t mk(input logic [31:0] instr, input logic [31:0] eres,
                                input logic [31:0] rt, input logic [4:0] exc);
        ein_t e;
        e.instr = instr;
        e.pc    = $urandom & 32'hFFFF_FFFC;
        e.bd    = 1'($urandom_range(0, 1));
        e.wa    = 5'($urandom_range(0, 31));
        e.eres  = eres;
        e.rt    = rt;
        e.exc   = exc;
        return e;
    endfunction

    function automatic mside_t ms(input logic sel, input logic [31:0] w,
                                  input logic [31:0] rd, input logic intr);
        mside_t m;
        m.sel = sel; m.w = w; m.rd = rd; m.intr = intr;
        return m;
    endfunction

    function automatic spot_t sp(input logic [3:0] mask, input logic [3:0] be,
                                 input logic [4:0] exc, input logic [31:0] wd, input logic [31:0] ld);
        spot_t s;
        s.mask = mask; s.be = be; s.exc = exc; s.wd = wd; s.ld = ld;
        return s;
    endfunction

    // Behavioural rules: access size, legality by address ranges, lane arithmetic
    function automatic void model(input rec_t r, output logic [3:0] be, output logic [4:0] exc,
                                  output logic [31:0] wd, output logic [31:0] ld, output logic wd_ok);
        int unsigned sz = 0;
        logic ldop = 1'b0, stop = 1'b0, sgn = 1'b0;
        logic [31:0] a = r.e.eres;
        logic t0, t1, dm, bad, cnt;
        logic [31:0] d, v, mask;
        int unsigned sh;
        case (r.e.instr[31:26])
            6'h23: begin sz = 4; ldop = 1'b1; end
            6'h21: begin sz = 2; ldop = 1'b1; sgn = 1'b1; end
            6'h25: begin sz = 2; ldop = 1'b1; end
            6'h20: begin sz = 1; ldop = 1'b1; sgn = 1'b1; end
            6'h24: begin sz = 1; ldop = 1'b1; end
            6'h2B: begin sz = 4; stop = 1'b1; end
            6'h29: begin sz = 2; stop = 1'b1; end
            6'h28: begin sz = 1; stop = 1'b1; end
            default: sz = 0;
        endcase
        dm  = (a <= 32'h0000_2FFF);
        t0  = (a >= 32'h0000_7F00) && (a <= 32'h0000_7F0B);
        t1  = (a >= 32'h0000_7F10) && (a <= 32'h0000_7F1B);
        bad = ((sz != 0) && ((a % sz) != 0)) || ((sz < 4) && (t0 || t1)) || (!dm && !t0 && !t1);
        cnt = (t0 && (a - 32'h0000_7F00) >= 32'd8) || (t1 && (a - 32'h0000_7F10) >= 32'd8);
        if (r.e.exc == 5'd12)      exc = ldop ? 5'd4 : (stop ? 5'd5 : 5'd12);
        else if (r.e.exc != 5'd0)  exc = r.e.exc;
        else if (ldop && bad)      exc = 5'd4;
        else if (stop && (bad || cnt)) exc = 5'd5;
        else                       exc = 5'd0;
        be = (stop && exc == 5'd0 && !r.m.intr) ? 4'(((32'd1 << sz) - 32'd1) << a[1:0]) : 4'b0000;
        d = r.m.sel ? r.m.w : r.e.rt;
        if (sz == 4)      wd = d;
        else if (sz == 2) wd = {16'h0000, d[15:0]} * 32'h0001_0001;
        else              wd = {24'h00_0000, d[7:0]} * 32'h0101_0101;
        wd_ok = stop || (r.bubble && !r.m.sel);
        if (r.bubble) wd = 32'h0000_0000;
        ld = 32'h0000_0000;
        if (ldop) begin
            sh   = (sz == 4) ? 0 : ((sz == 2) ? 16 * a[1] : 8 * a[1:0]);
            v    = r.m.rd >> sh;
            mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
            v    = v & mask;
            if (sgn && v[8 * sz - 1]) v = v | ~mask;
            ld   = v;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // One cycle: record what the register captured, then drive the next inputs
    task automatic step(input ein_t e, input mside_t m, input logic rst, input spot_t s);
        rec_t r;
        @(posedge clk);
        r.bubble = rst_drv || m_drv.intr;
        r.e      = r.bubble ? '0 : e_drv;
        #1;
        e_drv   = e;
        m_drv   = m;
        rst_drv = rst;
        r.m     = m;
        r.s     = s;
        exp_q.push_back(r);
        pushed++;
    endtask

    rec_t        cur;
    logic [3:0]  x_be;
    logic [4:0]  x_exc;
    logic [31:0] x_wd, x_ld;
    logic        x_wd_ok;

    // Monitor: pop the record for the instruction now in M and compare
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            popped++;
            model(cur, x_be, x_exc, x_wd, x_ld, x_wd_ok);
            chk("M_Instr", M_Instr, cur.e.instr);
            chk("M_PC", M_PC, cur.e.pc);
            chk("M_BD", {31'd0, M_BD}, {31'd0, cur.e.bd});
            chk("M_EResult", M_EResult, cur.e.eres);
            chk("M_WriteA", {27'd0, M_WriteA}, {27'd0, cur.e.wa});
            chk("DMAddr", DMAddr, cur.e.eres);
            chk("ExcCode", {27'd0, ExcCode}, {27'd0, x_exc});
            chk("DMByteEn", {28'd0, DMByteEn}, {28'd0, x_be});
            chk("LoadData", LoadData, x_ld);
            if (x_wd_ok) chk("DMWData", DMWData, x_wd);
            if (cur.s.mask[3]) chk("spot_be", {28'd0, DMByteEn}, {28'd0, cur.s.be});
            if (cur.s.mask[2]) chk("spot_exc", {27'd0, ExcCode}, {27'd0, cur.s.exc});
            if (cur.s.mask[1]) chk("spot_wdata", DMWData, cur.s.wd);
            if (cur.s.mask[0]) chk("spot_load", LoadData, cur.s.ld);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        mside_t m0;
        spot_t  ns;
        m0 = ms(1'b0, 32'h0, 32'h0, 1'b0);
        ns = '0;
        // reset cycles
        step(mk(32'h0, 32'h0, 32'h0, 5'd0), m0, 1'b1, ns);
        step(mk(32'h0, 32'h0, 32'h0, 5'd0), m0, 1'b1, ns);
        // directed sequence; each spot applies to the instruction issued one step earlier
        step(mk(mop(6'h2B), 32'h4, 32'h1234_5678, 5'd0), m0, 1'b0, sp(4'hF, 4'h0, 5'd0, 32'h0, 32'h0));
        step(mk(mop(6'h28), 32'h102, 32'h0000_00AB, 5'd0), m0, 1'b0, sp(4'hE, 4'hF, 5'd0, 32'h1234_5678, 32'h0));
        step(mk(mop(6'h20), 32'h102, 32'h0, 5'd0), m0, 1'b0, sp(4'hA, 4'b0100, 5'd0, 32'hABAB_ABAB, 32'h0));
        step(mk(mop(6'h24), 32'h102, 32'h0, 5'd0), ms(1'b0, 32'h0, 32'h00AB_0000, 1'b0), 1'b0,
             sp(4'h1, 4'h0, 5'd0, 32'h0, 32'hFFFF_FFAB));
        step(mk(mop(6'h21), 32'h3, 32'h0, 5'd0), ms(1'b0, 32'h0, 32'h00AB_0000, 1'b0), 1'b0,
             sp(4'h1, 4'h0, 5'd0, 32'h0, 32'h0000_00AB));
        step(mk(mop(6'h2B), 32'h7F08, 32'h1111_2222, 5'd0), m0, 1'b0, sp(4'hC, 4'h0, 5'd4, 32'h0, 32'h0));
        step(mk(mop(6'h2B), 32'h7F04, 32'h3333_4444, 5'd0), m0, 1'b0, sp(4'hC, 4'h0, 5'd5, 32'h0, 32'h0));
        step(mk(mop(6'h23), 32'h4, 32'h0, 5'd12), m0, 1'b0, sp(4'hC, 4'hF, 5'd0, 32'h0, 32'h0));
        step(mk(ADD_I, 32'h8000_0000, 32'h0, 5'd12), m0, 1'b0, sp(4'h4, 4'h0, 5'd4, 32'h0, 32'h0));
        step(mk(mop(6'h2B), 32'h0, 32'h0, 5'd10), m0, 1'b0, sp(4'h4, 4'h0, 5'd12, 32'h0, 32'h0));
        step(mk(mop(6'h2B), 32'h8, 32'h0000_0055, 5'd0), m0, 1'b0, sp(4'hC, 4'h0, 5'd10, 32'h0, 32'h0));
        step(mk(mop(6'h29), 32'h2, 32'h0, 5'd0), ms(1'b0, 32'h0, 32'h0, 1'b1), 1'b0,
             sp(4'h8, 4'h0, 5'd0, 32'h0, 32'h0));
        step(mk(mop(6'h29), 32'h2, 32'h1111_2222, 5'd0), m0, 1'b0, sp(4'hE, 4'h0, 5'd0, 32'h0, 32'h0));
        step(mk(mop(6'h2B), 32'h10, 32'h0000_DEAD, 5'd0), ms(1'b1, 32'hCAFE_BABE, 32'h0, 1'b0), 1'b0,
             sp(4'hA, 4'b1100, 5'd0, 32'hBABE_BABE, 32'h0));
        step(mk(mop(6'h2B), 32'h14, 32'h0000_BEEF, 5'd0), m0, 1'b1, sp(4'hA, 4'hF, 5'd0, 32'h0000_DEAD, 32'h0));
        step(mk(32'h0, 32'h0, 32'h0, 5'd0), m0, 1'b0, sp(4'hF, 4'h0, 5'd0, 32'h0, 32'h0));
        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] instr, addr;
            logic [4:0]  exc;
            int          k;
            k = $urandom_range(0, 9);
            if (k < 8)       instr = mop(ops[k]);
            else if (k == 8) instr = ADD_I;
            else             instr = 32'h0;
            case ($urandom_range(0, 3))
                0:       addr = $urandom_range(0, 32'h2FFF);
                1:       addr = 32'h7F00 + $urandom_range(0, 31);
                2:       addr = $urandom;
                default: addr = 32'h2FF8 + $urandom_range(0, 15);
            endcase
            if ($urandom_range(0, 1) == 0) addr = addr & 32'hFFFF_FFFC;
            k = $urandom_range(0, 9);
            exc = (k < 7) ? 5'd0 : ((k < 9) ? 5'd12 : 5'd10);
            step(mk(instr, addr, $urandom, exc),
                 ms(1'($urandom_range(0, 1)), $urandom, $urandom, ($urandom_range(0, 9) == 0)),
                 ($urandom_range(0, 49) == 0), ns);
        end
        step(mk(32'h0, 32'h0, 32'h0, 5'd0), m0, 1'b0, ns);
        step(mk(32'h0, 32'h0, 32'h0, 5'd0), m0, 1'b0, ns);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", popped, pushed);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
